// File: rtl/sampler_channel_registers.sv
// Register bank for the multi-voice sampler: global control/IRQ block plus one
// four-word register group per voice, with byte-enable writes and start/stop handshakes.
module sampler_channel_registers #(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_BITS    = 6,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter logic [31:0] VERSION      = 32'h0002_0000
) (
  input  logic                              axi_clk,
  input  logic                              axi_reset,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              data_wren,
  input  logic [ADDR_BITS-1:0]              reg_addr_wr,
  input  logic [3:0]                        byte_enable,
  input  logic [ADDR_BITS-1:0]              reg_addr_rd,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              global_enable,
  output logic                              irq,
  output logic [NUM_CHANNELS-1:0]           ch_start_req,
  input  logic [NUM_CHANNELS-1:0]           ch_start_ack,
  output logic [NUM_CHANNELS-1:0]           ch_stop,
  output logic [NUM_CHANNELS-1:0]           ch_loop,
  output logic [32*NUM_CHANNELS-1:0]        ch_addr,
  output logic [32*NUM_CHANNELS-1:0]        ch_len,
  input  logic [NUM_CHANNELS-1:0]           ch_busy,
  input  logic [COUNT_WIDTH*NUM_CHANNELS-1:0] ch_count,
  input  logic [NUM_CHANNELS-1:0]           ch_done
);

  localparam int unsigned NC   = NUM_CHANNELS;
  localparam int unsigned HI_W = ADDR_BITS - 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  state_t                r_state [NC];
  state_t                w_state_nxt [NC];
  logic [NC-1:0]         w_ovr_set;

  logic                  r_global_enable;
  logic                  r_irq;
  logic [NC-1:0]         r_irq_status;
  logic [NC-1:0]         r_irq_enable;
  logic [NC-1:0]         r_loop;
  logic [NC-1:0]         r_overrun;
  logic [NC-1:0]         r_stop;
  logic [31:0]           r_addr [NC];
  logic [31:0]           r_len  [NC];
  logic [DATA_WIDTH-1:0] r_data_out;

  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_gctrl_wr, w_istat_wr, w_ien_wr;
  logic [NC-1:0]         w_ctrl_wr, w_caddr_wr, w_clen_wr, w_cstat_wr;
  logic [NC-1:0]         w_start_wr, w_stop_wr, w_ovr_clr, w_istat_clr;
  logic [DATA_WIDTH-1:0] w_rdata;

  // A zero byte_enable means a full-word write for legacy callers.
  always_comb begin
    w_be = (byte_enable == 4'h0) ? 4'hF : byte_enable;
    for (int unsigned b = 0; b < 4; b++) w_mask[8*b +: 8] = {8{w_be[b]}};
  end

  // Write address decode.
  always_comb begin
    w_gctrl_wr = 1'b0;
    w_istat_wr = 1'b0;
    w_ien_wr   = 1'b0;
    w_ctrl_wr  = '0;
    w_caddr_wr = '0;
    w_clen_wr  = '0;
    w_cstat_wr = '0;
    if (data_wren && reg_addr_wr[ADDR_BITS-1:2] == HI_W'(0)) begin
      w_gctrl_wr = (reg_addr_wr[1:0] == 2'd0);
      w_istat_wr = (reg_addr_wr[1:0] == 2'd1);
      w_ien_wr   = (reg_addr_wr[1:0] == 2'd2);
    end
    for (int unsigned c = 0; c < NC; c++) begin
      if (data_wren && reg_addr_wr[ADDR_BITS-1:2] == HI_W'(c + 2)) begin
        w_ctrl_wr[c]  = (reg_addr_wr[1:0] == 2'd0);
        w_caddr_wr[c] = (reg_addr_wr[1:0] == 2'd1);
        w_clen_wr[c]  = (reg_addr_wr[1:0] == 2'd2);
        w_cstat_wr[c] = (reg_addr_wr[1:0] == 2'd3);
      end
    end
    w_start_wr  = w_ctrl_wr  & {NC{w_be[0] & data_in[0]}};
    w_stop_wr   = w_ctrl_wr  & {NC{w_be[0] & data_in[2]}};
    w_ovr_clr   = w_cstat_wr & {NC{w_be[0] & data_in[1]}};
    w_istat_clr = {NC{w_istat_wr}} & data_in[NC-1:0] & w_mask[NC-1:0];
  end

  // Start-handshake FSM: state register.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      for (int unsigned c = 0; c < NC; c++) r_state[c] <= ST_IDLE;
    end else begin
      for (int unsigned c = 0; c < NC; c++) r_state[c] <= w_state_nxt[c];
    end
  end

  // Start-handshake FSM: next state; stop overrides everything, including a same-write start.
  always_comb begin
    w_ovr_set = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      w_state_nxt[c] = r_state[c];
      if (w_stop_wr[c]) begin
        w_state_nxt[c] = ST_IDLE;
      end else begin
        case (r_state[c])
          ST_IDLE: if (w_start_wr[c]) w_state_nxt[c] = ST_REQ;
          ST_REQ: begin
            w_ovr_set[c] = w_start_wr[c];
            if (ch_start_ack[c]) w_state_nxt[c] = ST_IDLE;
          end
          default: w_state_nxt[c] = ST_IDLE;
        endcase
      end
    end
  end

  // Start-handshake FSM: outputs.
  always_comb begin
    for (int unsigned c = 0; c < NC; c++) ch_start_req[c] = (r_state[c] == ST_REQ);
  end

  // Register file; status set events win over same-cycle W1C clears.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_global_enable <= 1'b0;
      r_irq           <= 1'b0;
      r_irq_status    <= '0;
      r_irq_enable    <= '0;
      r_loop          <= '0;
      r_overrun       <= '0;
      r_stop          <= '0;
      r_data_out      <= '0;
      for (int unsigned c = 0; c < NC; c++) begin
        r_addr[c] <= '0;
        r_len[c]  <= '0;
      end
    end else begin
      r_stop       <= w_stop_wr;
      r_irq_status <= (r_irq_status & ~w_istat_clr) | ch_done;
      r_irq        <= |(r_irq_status & r_irq_enable);
      r_overrun    <= (r_overrun & ~w_ovr_clr) | w_ovr_set;
      r_data_out   <= w_rdata;
      if (w_gctrl_wr && w_be[0]) r_global_enable <= data_in[0];
      if (w_ien_wr)
        r_irq_enable <= (r_irq_enable & ~w_mask[NC-1:0]) | (data_in[NC-1:0] & w_mask[NC-1:0]);
      for (int unsigned c = 0; c < NC; c++) begin
        if (w_ctrl_wr[c] && w_be[0]) r_loop[c] <= data_in[1];
        if (w_caddr_wr[c]) r_addr[c] <= (r_addr[c] & ~w_mask) | (data_in & w_mask);
        if (w_clen_wr[c])  r_len[c]  <= (r_len[c]  & ~w_mask) | (data_in & w_mask);
      end
    end
  end

  // Read mux; start/stop bits and unmapped space read as zero.
  always_comb begin
    w_rdata = '0;
    if (reg_addr_rd[ADDR_BITS-1:2] == HI_W'(0)) begin
      case (reg_addr_rd[1:0])
        2'd0:    w_rdata = 32'(r_global_enable);
        2'd1:    w_rdata = 32'(r_irq_status);
        2'd2:    w_rdata = 32'(r_irq_enable);
        default: w_rdata = VERSION;
      endcase
    end
    for (int unsigned c = 0; c < NC; c++) begin
      if (reg_addr_rd[ADDR_BITS-1:2] == HI_W'(c + 2)) begin
        case (reg_addr_rd[1:0])
          2'd0:    w_rdata = {30'b0, r_loop[c], 1'b0};
          2'd1:    w_rdata = r_addr[c];
          2'd2:    w_rdata = r_len[c];
          default: w_rdata = {16'(ch_count[c*COUNT_WIDTH +: COUNT_WIDTH]), 14'b0,
                              r_overrun[c], ch_busy[c]};
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NC; c++) begin
      ch_addr[32*c +: 32] = r_addr[c];
      ch_len[32*c +: 32]  = r_len[c];
    end
  end

  assign data_out      = r_data_out;
  assign global_enable = r_global_enable;
  assign irq           = r_irq;
  assign ch_stop       = r_stop;
  assign ch_loop       = r_loop;

endmodule

// File: tb/tb_sampler_channel_registers.sv
// Bench for sampler_channel_registers: fixed vectors, handshake/IRQ/reset sequences,
// then random traffic against a register-map reference model.
module tb_sampler_channel_registers;

  localparam int unsigned NCH = 8;
  localparam logic [31:0] VER = 32'h0002_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  din = '0;
  logic         wren = 1'b0;
  logic [5:0]   waddr = '0;
  logic [3:0]   be = '0;
  logic [5:0]   raddr = '0;
  logic [NCH-1:0] ack = '0, busy = '0, done = '0;
  logic [16*NCH-1:0] count = '0;

  logic [31:0]      data_out;
  logic             global_enable, irq;
  logic [NCH-1:0]   ch_start_req, ch_stop, ch_loop;
  logic [32*NCH-1:0] ch_addr, ch_len;

  int n_checks = 0;
  int n_errors = 0;

  sampler_channel_registers dut (
    .axi_clk(clk), .axi_reset(rst), .data_in(din), .data_wren(wren),
    .reg_addr_wr(waddr), .byte_enable(be), .reg_addr_rd(raddr),
    .data_out(data_out), .global_enable(global_enable), .irq(irq),
    .ch_start_req(ch_start_req), .ch_start_ack(ack), .ch_stop(ch_stop),
    .ch_loop(ch_loop), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_busy(busy), .ch_count(count), .ch_done(done)
  );

  always #5 clk = ~clk;

  // Reference model of the register map.
  bit          m_gen, m_irq;
  bit [NCH-1:0] m_ist, m_ien, m_loop, m_req, m_ovr, m_stop;
  logic [31:0] m_addr [NCH];
  logic [31:0] m_len  [NCH];
  logic [31:0] m_dout;

  function automatic logic [31:0] m_rd(logic [5:0] a);
    int ai;
    int c;
    ai = int'(a);
    if (ai == 0) return {31'b0, m_gen};
    if (ai == 1) return 32'(m_ist);
    if (ai == 2) return 32'(m_ien);
    if (ai == 3) return VER;
    if (ai >= 8 && ai < 8 + 4*NCH) begin
      c = (ai - 8) / 4;
      case ((ai - 8) % 4)
        0: return {30'b0, m_loop[c], 1'b0};
        1: return m_addr[c];
        2: return m_len[c];
        default: return {count[c*16 +: 16], 14'b0, m_ovr[c], busy[c]};
      endcase
    end
    return 32'h0;
  endfunction

  function automatic void model_step();
    logic [3:0]  be_e;
    logic [31:0] mask;
    bit [NCH-1:0] start, stop, clr;
    int ai, c;
    if (rst) begin
      m_gen = 0; m_irq = 0; m_ist = 0; m_ien = 0; m_loop = 0; m_req = 0;
      m_ovr = 0; m_stop = 0; m_dout = 0;
      for (int i = 0; i < NCH; i++) begin m_addr[i] = 0; m_len[i] = 0; end
      return;
    end
    m_dout = m_rd(raddr);
    m_irq  = |(m_ist & m_ien);
    be_e = (be == 4'h0) ? 4'hF : be;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{be_e[b]}};
    start = 0; stop = 0; clr = 0;
    ai = int'(waddr);
    if (wren) begin
      if (ai == 0 && be_e[0]) m_gen = din[0];
      if (ai == 1) clr = din[NCH-1:0] & mask[NCH-1:0];
      if (ai == 2) m_ien = (m_ien & ~mask[NCH-1:0]) | (din[NCH-1:0] & mask[NCH-1:0]);
      if (ai >= 8 && ai < 8 + 4*NCH) begin
        c = (ai - 8) / 4;
        case ((ai - 8) % 4)
          0: if (be_e[0]) begin m_loop[c] = din[1]; start[c] = din[0]; stop[c] = din[2]; end
          1: m_addr[c] = (m_addr[c] & ~mask) | (din & mask);
          2: m_len[c]  = (m_len[c] & ~mask) | (din & mask);
          default: if (be_e[0] && din[1]) m_ovr[c] = 0;
        endcase
      end
    end
    m_ist = (m_ist & ~clr) | done;
    for (int i = 0; i < NCH; i++) begin
      if (stop[i]) m_req[i] = 0;
      else if (m_req[i]) begin
        if (start[i]) m_ovr[i] = 1;
        if (ack[i]) m_req[i] = 0;
      end else if (start[i]) m_req[i] = 1;
    end
    m_stop = stop;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(string name, logic [255:0] got, logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic void check_all(int cyc);
    logic [32*NCH-1:0] ea, el;
    for (int i = 0; i < NCH; i++) begin ea[32*i +: 32] = m_addr[i]; el[32*i +: 32] = m_len[i]; end
    chk($sformatf("rnd%0d data_out", cyc), 256'(data_out), 256'(m_dout));
    chk($sformatf("rnd%0d irq", cyc), 256'(irq), 256'(m_irq));
    chk($sformatf("rnd%0d global_enable", cyc), 256'(global_enable), 256'(m_gen));
    chk($sformatf("rnd%0d ch_start_req", cyc), 256'(ch_start_req), 256'(m_req));
    chk($sformatf("rnd%0d ch_stop", cyc), 256'(ch_stop), 256'(m_stop));
    chk($sformatf("rnd%0d ch_loop", cyc), 256'(ch_loop), 256'(m_loop));
    chk($sformatf("rnd%0d ch_addr", cyc), 256'(ch_addr), 256'(ea));
    chk($sformatf("rnd%0d ch_len", cyc), 256'(ch_len), 256'(el));
  endfunction

  task automatic wr(logic [5:0] a, logic [31:0] d, logic [3:0] e);
    wren = 1'b1; waddr = a; din = d; be = e;
    cycle();
    wren = 1'b0;
  endtask

  typedef struct {
    bit          do_wr;
    logic [5:0]  waddr;
    logic [3:0]  be;
    logic [31:0] din;
    logic [5:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  initial begin
    vecs[0]  = '{1'b0, 6'd0,  4'h0, 32'h0,         6'd3,  VER};
    vecs[1]  = '{1'b0, 6'd0,  4'h0, 32'h0,         6'd1,  32'h0};
    vecs[2]  = '{1'b0, 6'd0,  4'h0, 32'h0,         6'd2,  32'h0};
    vecs[3]  = '{1'b0, 6'd0,  4'h0, 32'h0,         6'd0,  32'h0};
    vecs[4]  = '{1'b0, 6'd0,  4'h0, 32'h0,         6'd4,  32'h0};
    vecs[5]  = '{1'b0, 6'd0,  4'h0, 32'h0,         6'h3F, 32'h0};
    vecs[6]  = '{1'b1, 6'd17, 4'h3, 32'hDEAD_BEEF, 6'd17, 32'h0000_BEEF};
    vecs[7]  = '{1'b1, 6'd17, 4'h0, 32'h1234_5678, 6'd17, 32'h1234_5678};
    vecs[8]  = '{1'b1, 6'd0,  4'h2, 32'hFFFF_FFFF, 6'd0,  32'h0};
    vecs[9]  = '{1'b1, 6'd0,  4'h1, 32'h0000_0001, 6'd0,  32'h1};
    vecs[10] = '{1'b1, 6'd3,  4'h0, 32'h0,         6'd3,  VER};
    vecs[11] = '{1'b1, 6'd18, 4'hC, 32'hAABB_CCDD, 6'd18, 32'hAABB_0000};
    vecs[12] = '{1'b1, 6'd5,  4'h0, 32'hFFFF_FFFF, 6'd5,  32'h0};
    vecs[13] = '{1'b1, 6'd2,  4'h0, 32'h0000_00FF, 6'd2,  32'hFF};
    vecs[14] = '{1'b1, 6'd2,  4'h1, 32'h0,         6'd2,  32'h0};
    vecs[15] = '{1'b1, 6'd8,  4'h1, 32'hFFFF_FFFA, 6'd8,  32'h2};
    vecs[16] = '{1'b0, 6'd0,  4'h0, 32'h0,         6'd27, 32'h1234_0001};
    vecs[17] = '{1'b1, 6'd8,  4'h0, 32'h0,         6'd8,  32'h0};
    vecs[18] = '{1'b1, 6'd44, 4'h0, 32'hFFFF_FFFF, 6'd44, 32'h0};

    // Reset and reset-state checks.
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chk("reset data_out", 256'(data_out), 256'h0);
    chk("reset irq", 256'(irq), 256'h0);
    chk("reset global_enable", 256'(global_enable), 256'h0);
    chk("reset ch_start_req", 256'(ch_start_req), 256'h0);
    chk("reset ch_stop", 256'(ch_stop), 256'h0);
    chk("reset ch_addr", 256'(ch_addr), 256'h0);

    busy = 8'h10;
    count[4*16 +: 16] = 16'h1234;
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].din, vecs[i].be);
      raddr = vecs[i].raddr;
      cycle();
      chk($sformatf("vec%0d data_out", i), 256'(data_out), 256'(vecs[i].exp));
    end
    chk("ch2 ch_addr", 256'(ch_addr[95:64]), 256'h1234_5678);
    chk("ch2 ch_len", 256'(ch_len[95:64]), 256'hAABB_0000);
    chk("global_enable set", 256'(global_enable), 256'h1);
    busy = '0;
    count = '0;

    // Start handshake with overrun on ch0.
    wr(6'd8, 32'h1, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("hs req0 cycle%0d", k), 256'(ch_start_req[0]), 256'h1);
      if (k == 3) begin wren = 1'b1; waddr = 6'd8; din = 32'h1; be = 4'h1; end
      if (k == 6) ack[0] = 1'b1;
      cycle();
      wren = 1'b0;
      ack = '0;
    end
    chk("hs req0 cycle7", 256'(ch_start_req[0]), 256'h0);
    raddr = 6'd11;
    cycle();
    chk("hs overrun set", 256'(data_out), 256'h2);
    wr(6'd11, 32'h2, 4'h0);
    cycle();
    chk("hs overrun cleared", 256'(data_out), 256'h0);

    // IRQ set, lag, and set-beats-clear.
    wr(6'd2, 32'h1, 4'h0);
    done[0] = 1'b1;
    cycle();
    done = '0;
    chk("irq lag", 256'(irq), 256'h0);
    raddr = 6'd1;
    cycle();
    chk("irq high", 256'(irq), 256'h1);
    chk("irq status", 256'(data_out), 256'h1);
    done[0] = 1'b1;
    wr(6'd1, 32'h1, 4'h0);
    done = '0;
    cycle();
    chk("irq set beats clear", 256'(data_out), 256'h1);
    wr(6'd1, 32'h1, 4'h0);
    cycle();
    chk("irq status cleared", 256'(data_out), 256'h0);
    chk("irq low", 256'(irq), 256'h0);

    // Start+stop together on ch1: stop wins.
    wr(6'd12, 32'h5, 4'h1);
    chk("ss req1", 256'(ch_start_req[1]), 256'h0);
    chk("ss stop pulse", 256'(ch_stop), 256'h02);
    cycle();
    chk("ss stop end", 256'(ch_stop), 256'h0);
    chk("ss req1 after", 256'(ch_start_req[1]), 256'h0);

    // Reset during a pending request on ch3.
    wr(6'd20, 32'h1, 4'h0);
    chk("rst req3 pending", 256'(ch_start_req), 256'h08);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst req cleared", 256'(ch_start_req), 256'h0);
    chk("rst global_enable", 256'(global_enable), 256'h0);
    chk("rst ch_loop", 256'(ch_loop), 256'h0);
    chk("rst ch_len", 256'(ch_len), 256'h0);
    chk("rst data_out", 256'(data_out), 256'h0);
    raddr = 6'd23;
    cycle();
    chk("rst overrun", 256'(data_out), 256'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 79) == 0);
      wren  = $urandom_range(0, 1) == 1;
      waddr = 6'($urandom_range(0, 47));
      din   = $urandom;
      be    = 4'($urandom);
      raddr = 6'($urandom_range(0, 63));
      ack   = 8'($urandom) & 8'($urandom);
      done  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      busy  = 8'($urandom);
      count = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      check_all(n);
    end
    rst = 1'b0; wren = 1'b0; done = '0; ack = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
